feature_addr_gen: RTL and testbench
===================================

# feature_addr_gen

Upstream address sequencer for the rectangle ROM read ports. It takes a per-stage command (base feature address, feature count) and walks the feature indices. Each address is broadcast to N_PORTS rect ROM read ports (rect0/rect1/rect2) in lockstep, over per-port valid/ready handshakes. When the last address has been accepted by every port, it emits one completion token.

## Interface
- W_ADDR, 14, width of ROM feature address
- W_CNT, 12, width of per-stage feature count
- N_PORTS, 3, number of rect ROM read ports fed in lockstep
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- cmd_valid  in  1  stage command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_base  in  W_ADDR  first feature address of stage
- cmd_count  in  W_CNT  number of features in stage (0 legal)
- addr_valid  out  N_PORTS  per-port address valid, to addr1_valid of each rect port
- addr_ready  in  N_PORTS  per-port ready, from addr1_ready of each rect port
- addr_data  out  W_ADDR  current feature address, shared by all ports
- done_valid  out  1  stage-complete token
- done_ready  in  1  consumer accepts done token
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: cmd_ready=1. On cmd_valid:
  - Latch addr_data <= cmd_base and remaining <= cmd_count.
  - Clear accepted mask.
  - If cmd_count==0, go to DONE; otherwise go to RUN.
- RUN: cmd_ready=0.
  - addr_valid[i] = ~accepted[i].
  - A port handshake occurs when addr_valid[i] && addr_ready[i]. That port's bit is set in the accepted mask, and its valid drops the next cycle.
  - An address completes in the cycle when every port has either already accepted or is handshaking this cycle.
  - On completion, the mask clears and remaining decrements.
    - If remaining was 1, go to DONE.
    - Otherwise addr_data <= addr_data+1, stay in RUN.
  - addr_data is stable while any addr_valid bit is high.
- DONE: done_valid=1, held until done_ready. On the handshake, go to IDLE.
- Address arithmetic is modulo 2^W_ADDR: address 2^W_ADDR-1 wraps to 0 with no error.
- Ports may accept in any order and at any cycle. A slow port stalls only the advance, never the other ports' already-recorded acceptance.
- No valid is retracted before its handshake (AXI-stream rule).
- Commands are not accepted while busy; cmd_valid held by the source is accepted on the first cycle back in IDLE.
- Reset (rst=0, async):
  - state=IDLE, addr_valid=0, done_valid=0, busy=0.
  - addr_data=0, remaining=0, mask=0.
  - cmd_ready=1 once rst deasserts.
- Reset mid-RUN or mid-DONE aborts the stage immediately: the in-flight address is dropped and no done token is produced.

## Timing
- Command handshake at edge t: addr_valid = all-ones and addr_data = cmd_base from cycle t+1 (registered outputs).
- With all addr_ready held high, one address completes per cycle. Stage of count N: last address completes at edge t+N, done_valid high in cycle t+N+1.
- Count 0: done_valid high in cycle t+1, no addr_valid pulse.
- Done handshake at edge d: busy=0 and cmd_ready=1 in cycle d+1. Back-to-back stages therefore have a 2-cycle gap between the last address and the next first address.
- Per-port acceptance is visible the following cycle: addr_valid[i]=0 after port i handshakes, until the address completes.
- Outputs addr_valid, addr_data, done_valid and busy are driven from registers. cmd_ready is decoded from state only, with no combinational path from inputs.

## Test plan
- Reset, then command base=0x0010, count=4, all ready=1 -> addresses 0x10,0x11,0x12,0x13 on consecutive cycles on all three ports; done_valid one cycle after 0x13; cmd_ready low until the done handshake.
- Staggered ready: port0 ready at cycle 1, port1 at cycle 3, port2 at cycle 5 for address 0x20 -> each valid drops the cycle after its own handshake; address advances to 0x21 only after port2; no port sees 0x20 twice.
- count=0, base=0x3FFF -> no addr_valid, done_valid next cycle; done_ready held low 5 cycles -> done_valid stays high, busy=1.
- Wrap: base=0x3FFE, count=3 -> addresses 0x3FFE,0x3FFF,0x0000, then done.
- Back-to-back: second command held valid during the first stage -> accepted only in the cycle after the done handshake; its first address appears the following cycle.
- Assert rst=0 mid-RUN at address 0x45 -> all outputs go to reset values asynchronously; after release, cmd_ready=1 and no done token is emitted for the aborted stage.

Source files
------------

// File: rtl/feature_addr_gen.sv
// Feature address sequencer: walks base..base+count-1 and broadcasts each
// address to N_PORTS read ports in lockstep, then emits one done token.
module feature_addr_gen #(
   parameter int unsigned W_ADDR  = 14,
   parameter int unsigned W_CNT   = 12,
   parameter int unsigned N_PORTS = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [W_ADDR-1:0]  cmd_base,
   input  logic [W_CNT-1:0]   cmd_count,
   output logic [N_PORTS-1:0] addr_valid,
   input  logic [N_PORTS-1:0] addr_ready,
   output logic [W_ADDR-1:0]  addr_data,
   output logic               done_valid,
   input  logic               done_ready,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [W_CNT-1:0]   remaining;
   logic               addr_done;

   // Accepted mask is held inverted in addr_valid: a port is pending while its valid is high.
   always_comb begin
      addr_done = 1'b0;
      if (state == RUN) begin
         addr_done = &(~addr_valid | addr_ready);
      end
   end

   assign cmd_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         remaining  <= '0;
         addr_valid <= '0;
         addr_data  <= '0;
         done_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  addr_data <= cmd_base;
                  remaining <= cmd_count;
                  busy      <= 1'b1;
                  if (cmd_count == '0) begin
                     state      <= DONE;
                     done_valid <= 1'b1;
                  end else begin
                     state      <= RUN;
                     addr_valid <= {N_PORTS{1'b1}};
                  end
               end
            end
            RUN: begin
               if (addr_done) begin
                  remaining <= remaining - W_CNT'(1);
                  if (remaining == W_CNT'(1)) begin
                     state      <= DONE;
                     addr_valid <= '0;
                     done_valid <= 1'b1;
                  end else begin
                     addr_data  <= addr_data + W_ADDR'(1);
                     addr_valid <= {N_PORTS{1'b1}};
                  end
               end else begin
                  // Record each port's acceptance; others keep waiting on the same address.
                  addr_valid <= addr_valid & ~addr_ready;
               end
            end
            DONE: begin
               if (done_ready) begin
                  state      <= IDLE;
                  done_valid <= 1'b0;
                  busy       <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               addr_valid <= '0;
               done_valid <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_feature_addr_gen.sv
// Directed bench for feature_addr_gen: hand-computed address sequences and handshakes.
module tb_feature_addr_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [13:0] cmd_base;
   logic [11:0] cmd_count;
   logic [2:0]  addr_valid;
   logic [2:0]  addr_ready;
   logic [13:0] addr_data;
   logic        done_valid;
   logic        done_ready;
   logic        busy;

   int passed = 0;
   int total  = 0;

   feature_addr_gen dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_base   (cmd_base),
      .cmd_count  (cmd_count),
      .addr_valid (addr_valid),
      .addr_ready (addr_ready),
      .addr_data  (addr_data),
      .done_valid (done_valid),
      .done_ready (done_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Check the full output set in one call.
   task automatic chk_out(input string tag, input logic [2:0] v, input logic [13:0] d,
                          input logic dv, input logic b, input logic cr);
      chk({tag, ".addr_valid"}, 32'(addr_valid), 32'(v));
      chk({tag, ".addr_data"},  32'(addr_data),  32'(d));
      chk({tag, ".done_valid"}, 32'(done_valid), 32'(dv));
      chk({tag, ".busy"},       32'(busy),       32'(b));
      chk({tag, ".cmd_ready"},  32'(cmd_ready),  32'(cr));
   endtask

   task automatic send_cmd(input logic [13:0] base, input logic [11:0] count);
      cmd_valid = 1'b1;
      cmd_base  = base;
      cmd_count = count;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic finish_done();
      done_ready = 1'b1;
      step();
      done_ready = 1'b0;
   endtask

   initial begin
      rst        = 1'b0;
      cmd_valid  = 1'b0;
      cmd_base   = '0;
      cmd_count  = '0;
      addr_ready = '0;
      done_ready = 1'b0;
      step();
      step();
      chk_out("reset", 3'b000, 14'h0000, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      step();
      chk_out("idle", 3'b000, 14'h0000, 1'b0, 1'b0, 1'b1);

      // Stage 0x10 x4, all ports always ready.
      addr_ready = 3'b111;
      send_cmd(14'h0010, 12'd4);
      chk_out("s1.a0", 3'b111, 14'h0010, 1'b0, 1'b1, 1'b0);
      step();
      chk_out("s1.a1", 3'b111, 14'h0011, 1'b0, 1'b1, 1'b0);
      step();
      chk_out("s1.a2", 3'b111, 14'h0012, 1'b0, 1'b1, 1'b0);
      step();
      chk_out("s1.a3", 3'b111, 14'h0013, 1'b0, 1'b1, 1'b0);
      step();
      chk_out("s1.done", 3'b000, 14'h0013, 1'b1, 1'b1, 1'b0);
      step();
      chk_out("s1.hold", 3'b000, 14'h0013, 1'b1, 1'b1, 1'b0);
      finish_done();
      chk_out("s1.idle", 3'b000, 14'h0013, 1'b0, 1'b0, 1'b1);

      // Staggered per-port acceptance of 0x20.
      addr_ready = 3'b000;
      send_cmd(14'h0020, 12'd2);
      chk_out("s2.c1", 3'b111, 14'h0020, 1'b0, 1'b1, 1'b0);
      addr_ready = 3'b001;
      step();
      chk_out("s2.c2", 3'b110, 14'h0020, 1'b0, 1'b1, 1'b0);
      addr_ready = 3'b001;
      step();
      chk_out("s2.c3", 3'b110, 14'h0020, 1'b0, 1'b1, 1'b0);
      addr_ready = 3'b011;
      step();
      chk_out("s2.c4", 3'b100, 14'h0020, 1'b0, 1'b1, 1'b0);
      addr_ready = 3'b000;
      step();
      chk_out("s2.c5", 3'b100, 14'h0020, 1'b0, 1'b1, 1'b0);
      addr_ready = 3'b100;
      step();
      chk_out("s2.c6", 3'b111, 14'h0021, 1'b0, 1'b1, 1'b0);
      addr_ready = 3'b111;
      step();
      chk_out("s2.done", 3'b000, 14'h0021, 1'b1, 1'b1, 1'b0);
      finish_done();
      chk_out("s2.idle", 3'b000, 14'h0021, 1'b0, 1'b0, 1'b1);

      // Zero-count stage with a stalled done consumer.
      send_cmd(14'h3FFF, 12'd0);
      chk_out("s3.done", 3'b000, 14'h3FFF, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk_out("s3.stall", 3'b000, 14'h3FFF, 1'b1, 1'b1, 1'b0);
      end
      finish_done();
      chk_out("s3.idle", 3'b000, 14'h3FFF, 1'b0, 1'b0, 1'b1);

      // Address wrap at the top of the space.
      send_cmd(14'h3FFE, 12'd3);
      chk_out("s4.a0", 3'b111, 14'h3FFE, 1'b0, 1'b1, 1'b0);
      step();
      chk_out("s4.a1", 3'b111, 14'h3FFF, 1'b0, 1'b1, 1'b0);
      step();
      chk_out("s4.a2", 3'b111, 14'h0000, 1'b0, 1'b1, 1'b0);
      step();
      chk_out("s4.done", 3'b000, 14'h0000, 1'b1, 1'b1, 1'b0);
      finish_done();

      // Back-to-back: second command held valid through the first stage.
      cmd_valid = 1'b1;
      cmd_base  = 14'h0100;
      cmd_count = 12'd2;
      step();
      cmd_base  = 14'h0200;
      cmd_count = 12'd1;
      chk_out("s5.a0", 3'b111, 14'h0100, 1'b0, 1'b1, 1'b0);
      step();
      chk_out("s5.a1", 3'b111, 14'h0101, 1'b0, 1'b1, 1'b0);
      step();
      chk_out("s5.done", 3'b000, 14'h0101, 1'b1, 1'b1, 1'b0);
      finish_done();
      chk_out("s5.idle", 3'b000, 14'h0101, 1'b0, 1'b0, 1'b1);
      step();
      cmd_valid = 1'b0;
      chk_out("s5.b0", 3'b111, 14'h0200, 1'b0, 1'b1, 1'b0);
      step();
      chk_out("s5.bdone", 3'b000, 14'h0200, 1'b1, 1'b1, 1'b0);
      finish_done();

      // Asynchronous reset in the middle of a stage.
      send_cmd(14'h0040, 12'd10);
      for (int i = 0; i < 5; i++) step();
      chk_out("s6.a5", 3'b111, 14'h0045, 1'b0, 1'b1, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      chk_out("s6.rst", 3'b000, 14'h0000, 1'b0, 1'b0, 1'b1);
      step();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_out("s6.after", 3'b000, 14'h0000, 1'b0, 1'b0, 1'b1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
